cnn_tile_scheduler: RTL and testbench

- Loop-nest controller for the tiled convolution datapath (Tm x Tn MAC array).
- After a one-cycle start pulse, walks every output map tile, output pixel, input map tile and kernel position. Each step is issued as indices plus first/last accumulate tags over a valid/ready handshake.
- Waits for the datapath pipeline to drain, then signals done.
- Sits between the top-level launch logic and the cnn compute array; replaces free-running "wait 300 cycles" sequencing.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/cnn_loop_counter.sv | 36 +++
 rtl/cnn_tile_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_cnn_tile_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and constant helpers for the cnn tile scheduler
//
// Contents:
//   state_t   : scheduler FSM states (IDLE, RUN, DRAIN, DONE)
//   ceil_div  : integer ceiling division for tile-count derivation
//   idx_width : index width for a value range, never narrower than one bit
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int idx_width(input int range);
        return (range <= 2) ? 1 : $clog2(range);
    endfunction

endpackage

// File: rtl/cnn_loop_counter.sv
// rtl/cnn_loop_counter.sv - wrap-around loop counter used as one level of the loop nest
//
// Ports:
//   clk_i     : clock
//   reset_n_i : asynchronous active-low clear
//   inc_i     : advance by one this cycle
//   wrap_o    : inc_i while at MAX_p-1 (carry into the next-outer counter)
//   value_o   : current count, 0..MAX_p-1
module cnn_loop_counter #(
    parameter int MAX_p = 1,
    parameter int W_p   = 1
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           inc_i,
    output logic           wrap_o,
    output logic [W_p-1:0] value_o
);

    logic [W_p-1:0] r_value;
    logic           w_at_max;

    assign w_at_max = (32'(r_value) == 32'(MAX_p - 1));
    // Combinational carry so a whole chain of counters rolls over in one cycle
    assign wrap_o   = inc_i && w_at_max;
    assign value_o  = r_value;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_value <= '0;
        end else if (inc_i) begin
            r_value <= w_at_max ? '0 : r_value + W_p'(1);
        end
    end

endmodule

// File: rtl/cnn_tile_scheduler.sv
// rtl/cnn_tile_scheduler.sv - loop-nest step scheduler for the tiled convolution MAC array
//
// Ports:
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   start_i                 : single-cycle launch request (honoured only when idle)
//   busy_o, done_o          : busy from accepted start through done; done is a one-cycle pulse
//   step_valid_o/ready_i    : step handshake towards the datapath
//   m_base_o, m_cnt_o       : output-map tile base and active map count
//   n_base_o, n_cnt_o       : input-map tile base and active map count
//   row_o, col_o            : output pixel
//   in_row_o, in_col_o      : input pixel (row*S+ki, col*S+kj)
//   ki_o, kj_o              : kernel position
//   first_o, last_o         : accumulator overwrite / accumulator final tags
module cnn_tile_scheduler
    import cnn_pkg::*;
#(
    parameter int N_p    = 1,
    parameter int M_p    = 1,
    parameter int K_p    = 1,
    parameter int R_p    = 4,
    parameter int C_p    = 4,
    parameter int S_p    = 1,
    parameter int Tn_p   = 1,
    parameter int Tm_p   = 1,
    parameter int PIPE_p = 2
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      start_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      step_valid_o,
    input  logic                                      step_ready_i,
    output logic [idx_width(M_p)-1:0]                 m_base_o,
    output logic [idx_width(Tm_p+1)-1:0]              m_cnt_o,
    output logic [idx_width(N_p)-1:0]                 n_base_o,
    output logic [idx_width(Tn_p+1)-1:0]              n_cnt_o,
    output logic [idx_width(R_p)-1:0]                 row_o,
    output logic [idx_width(C_p)-1:0]                 col_o,
    output logic [idx_width((R_p-1)*S_p+K_p)-1:0]     in_row_o,
    output logic [idx_width((C_p-1)*S_p+K_p)-1:0]     in_col_o,
    output logic [idx_width(K_p)-1:0]                 ki_o,
    output logic [idx_width(K_p)-1:0]                 kj_o,
    output logic                                      first_o,
    output logic                                      last_o
);

    localparam int NT    = ceil_div(N_p, Tn_p);
    localparam int MT    = ceil_div(M_p, Tm_p);
    localparam int W_TO  = idx_width(MT);
    localparam int W_TI  = idx_width(NT);
    localparam int W_ROW = idx_width(R_p);
    localparam int W_COL = idx_width(C_p);
    localparam int W_K   = idx_width(K_p);
    localparam int W_M   = idx_width(M_p);
    localparam int W_MC  = idx_width(Tm_p + 1);
    localparam int W_N   = idx_width(N_p);
    localparam int W_NC  = idx_width(Tn_p + 1);
    localparam int W_IR  = idx_width((R_p - 1) * S_p + K_p);
    localparam int W_IC  = idx_width((C_p - 1) * S_p + K_p);
    localparam int W_DR  = idx_width(PIPE_p);

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic [W_DR-1:0] r_drain;

    logic             w_accept;
    logic             w_kj_wrap, w_ki_wrap, w_ti_wrap, w_col_wrap, w_row_wrap, w_to_wrap;
    logic [W_TO-1:0]  w_to;
    logic [W_ROW-1:0] w_row;
    logic [W_COL-1:0] w_col;
    logic [W_TI-1:0]  w_ti;
    logic [W_K-1:0]   w_ki;
    logic [W_K-1:0]   w_kj;

    logic [31:0] w_m_base, w_m_rem, w_n_base, w_n_rem;

    assign w_accept = r_valid && step_ready_i;

    // Loop nest, innermost first: kj -> ki -> ti -> col -> row -> to
    cnn_loop_counter #(.MAX_p(K_p), .W_p(W_K)) u_kj (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(w_accept),
        .wrap_o(w_kj_wrap), .value_o(w_kj)
    );
    cnn_loop_counter #(.MAX_p(K_p), .W_p(W_K)) u_ki (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(w_kj_wrap),
        .wrap_o(w_ki_wrap), .value_o(w_ki)
    );
    cnn_loop_counter #(.MAX_p(NT), .W_p(W_TI)) u_ti (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(w_ki_wrap),
        .wrap_o(w_ti_wrap), .value_o(w_ti)
    );
    cnn_loop_counter #(.MAX_p(C_p), .W_p(W_COL)) u_col (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(w_ti_wrap),
        .wrap_o(w_col_wrap), .value_o(w_col)
    );
    cnn_loop_counter #(.MAX_p(R_p), .W_p(W_ROW)) u_row (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(w_col_wrap),
        .wrap_o(w_row_wrap), .value_o(w_row)
    );
    cnn_loop_counter #(.MAX_p(MT), .W_p(W_TO)) u_to (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(w_row_wrap),
        .wrap_o(w_to_wrap), .value_o(w_to)
    );

    // The outermost carry fires only on the final step; the whole nest is back at zero afterwards
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_drain <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_to_wrap) begin
                        r_valid <= 1'b0;
                        if (PIPE_p == 0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_drain <= W_DR'(PIPE_p - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - W_DR'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign step_valid_o = r_valid;

    // Tile bases and the partial-tile counts for the trailing tile
    assign w_m_base = 32'(w_to) * 32'(Tm_p);
    assign w_m_rem  = 32'(M_p) - w_m_base;
    assign w_n_base = 32'(w_ti) * 32'(Tn_p);
    assign w_n_rem  = 32'(N_p) - w_n_base;

    assign m_base_o = W_M'(w_m_base);
    assign m_cnt_o  = W_MC'((w_m_rem < 32'(Tm_p)) ? w_m_rem : 32'(Tm_p));
    assign n_base_o = W_N'(w_n_base);
    assign n_cnt_o  = W_NC'((w_n_rem < 32'(Tn_p)) ? w_n_rem : 32'(Tn_p));

    assign row_o    = w_row;
    assign col_o    = w_col;
    assign ki_o     = w_ki;
    assign kj_o     = w_kj;
    assign in_row_o = W_IR'(32'(w_row) * 32'(S_p) + 32'(w_ki));
    assign in_col_o = W_IC'(32'(w_col) * 32'(S_p) + 32'(w_kj));

    assign first_o = (w_ti == '0) && (w_ki == '0) && (w_kj == '0);
    assign last_o  = (32'(w_ti) == 32'(NT - 1)) &&
                     (32'(w_ki) == 32'(K_p - 1)) &&
                     (32'(w_kj) == 32'(K_p - 1));

endmodule

// File: tb/tb_cnn_tile_scheduler.sv
// tb/tb_cnn_tile_scheduler.sv - self-checking bench for cnn_tile_scheduler
module tb_cnn_tile_scheduler;
    import cnn_pkg::*;

    localparam int PIPE = 2;

    typedef struct packed {
        logic [7:0] m_base, m_cnt, n_base, n_cnt, row, col, in_row, in_col, ki, kj;
        logic       first, last;
    } step_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1;
    int   sel = 0;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    logic a_start, b_start, c_start;
    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);
    assign c_start = start && (sel == 2);

    // A: defaults
    logic a_busy, a_done, a_valid, a_first, a_last;
    logic [idx_width(1)-1:0] a_m_base, a_m_cnt, a_n_base, a_n_cnt, a_ki, a_kj;
    logic [idx_width(4)-1:0] a_row, a_col, a_in_row, a_in_col;
    cnn_tile_scheduler u_a (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
        .step_valid_o(a_valid), .step_ready_i(ready), .m_base_o(a_m_base), .m_cnt_o(a_m_cnt),
        .n_base_o(a_n_base), .n_cnt_o(a_n_cnt), .row_o(a_row), .col_o(a_col),
        .in_row_o(a_in_row), .in_col_o(a_in_col), .ki_o(a_ki), .kj_o(a_kj),
        .first_o(a_first), .last_o(a_last)
    );

    // B: N=3 M=4 K=3 R=C=4 S=1 Tn=Tm=2
    logic b_busy, b_done, b_valid, b_first, b_last;
    logic [idx_width(4)-1:0] b_m_base, b_row, b_col;
    logic [idx_width(3)-1:0] b_m_cnt, b_n_base, b_n_cnt, b_ki, b_kj;
    logic [idx_width(6)-1:0] b_in_row, b_in_col;
    cnn_tile_scheduler #(.N_p(3), .M_p(4), .K_p(3), .R_p(4), .C_p(4), .S_p(1),
                         .Tn_p(2), .Tm_p(2), .PIPE_p(PIPE)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
        .step_valid_o(b_valid), .step_ready_i(ready), .m_base_o(b_m_base), .m_cnt_o(b_m_cnt),
        .n_base_o(b_n_base), .n_cnt_o(b_n_cnt), .row_o(b_row), .col_o(b_col),
        .in_row_o(b_in_row), .in_col_o(b_in_col), .ki_o(b_ki), .kj_o(b_kj),
        .first_o(b_first), .last_o(b_last)
    );

    // C: S=2 K=3 R=C=2
    logic c_busy, c_done, c_valid, c_first, c_last;
    logic [idx_width(1)-1:0] c_m_base, c_n_base;
    logic [idx_width(2)-1:0] c_m_cnt, c_n_cnt, c_row, c_col;
    logic [idx_width(3)-1:0] c_ki, c_kj;
    logic [idx_width(5)-1:0] c_in_row, c_in_col;
    cnn_tile_scheduler #(.N_p(1), .M_p(1), .K_p(3), .R_p(2), .C_p(2), .S_p(2),
                         .Tn_p(1), .Tm_p(1), .PIPE_p(PIPE)) u_c (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(c_start), .busy_o(c_busy), .done_o(c_done),
        .step_valid_o(c_valid), .step_ready_i(ready), .m_base_o(c_m_base), .m_cnt_o(c_m_cnt),
        .n_base_o(c_n_base), .n_cnt_o(c_n_cnt), .row_o(c_row), .col_o(c_col),
        .in_row_o(c_in_row), .in_col_o(c_in_col), .ki_o(c_ki), .kj_o(c_kj),
        .first_o(c_first), .last_o(c_last)
    );

    logic  o_busy, o_done, o_valid;
    step_t cur;

    always_comb begin
        o_busy = 1'b0; o_done = 1'b0; o_valid = 1'b0; cur = '0;
        case (sel)
            0: begin
                o_busy = a_busy; o_done = a_done; o_valid = a_valid;
                cur = '{8'(a_m_base), 8'(a_m_cnt), 8'(a_n_base), 8'(a_n_cnt), 8'(a_row), 8'(a_col),
                        8'(a_in_row), 8'(a_in_col), 8'(a_ki), 8'(a_kj), a_first, a_last};
            end
            1: begin
                o_busy = b_busy; o_done = b_done; o_valid = b_valid;
                cur = '{8'(b_m_base), 8'(b_m_cnt), 8'(b_n_base), 8'(b_n_cnt), 8'(b_row), 8'(b_col),
                        8'(b_in_row), 8'(b_in_col), 8'(b_ki), 8'(b_kj), b_first, b_last};
            end
            default: begin
                o_busy = c_busy; o_done = c_done; o_valid = c_valid;
                cur = '{8'(c_m_base), 8'(c_m_cnt), 8'(c_n_base), 8'(c_n_cnt), 8'(c_row), 8'(c_col),
                        8'(c_in_row), 8'(c_in_col), 8'(c_ki), 8'(c_kj), c_first, c_last};
            end
        endcase
    end

    step_t exp_q[$], obs_q[$];
    int    stall_breaks, done_cnt, done_cyc, last_acc, late_act;
    bit    timed_out;

    // Reference: expected step list straight from the loop-nest definition
    task automatic build_model();
        int n, m, k, r, c, s, tn, tm, mt, nt;
        step_t st;
        case (sel)
            0:       begin n = 1; m = 1; k = 1; r = 4; c = 4; s = 1; tn = 1; tm = 1; end
            1:       begin n = 3; m = 4; k = 3; r = 4; c = 4; s = 1; tn = 2; tm = 2; end
            default: begin n = 1; m = 1; k = 3; r = 2; c = 2; s = 2; tn = 1; tm = 1; end
        endcase
        mt = (m + tm - 1) / tm;
        nt = (n + tn - 1) / tn;
        exp_q.delete();
        for (int to = 0; to < mt; to++)
            for (int row = 0; row < r; row++)
                for (int col = 0; col < c; col++)
                    for (int ti = 0; ti < nt; ti++)
                        for (int ki = 0; ki < k; ki++)
                            for (int kj = 0; kj < k; kj++) begin
                                st.m_base = 8'(to * tm);
                                st.m_cnt  = 8'((m - to * tm < tm) ? m - to * tm : tm);
                                st.n_base = 8'(ti * tn);
                                st.n_cnt  = 8'((n - ti * tn < tn) ? n - ti * tn : tn);
                                st.row    = 8'(row);
                                st.col    = 8'(col);
                                st.in_row = 8'(row * s + ki);
                                st.in_col = 8'(col * s + kj);
                                st.ki     = 8'(ki);
                                st.kj     = 8'(kj);
                                st.first  = (ti == 0) && (ki == 0) && (kj == 0);
                                st.last   = (ti == nt - 1) && (ki == k - 1) && (kj == k - 1);
                                exp_q.push_back(st);
                            end
    endtask

    // Drives one job; records accepted steps, stall stability, done timing
    task automatic run_job(input int stall_pct, input bit poke);
        int    cyc;
        bit    prev_stall;
        step_t saved;
        obs_q.delete();
        stall_breaks = 0; done_cnt = 0; done_cyc = -1; last_acc = -1; late_act = 0;
        timed_out = 1'b0; prev_stall = 1'b0; saved = '0;
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (1) begin
            if (prev_stall && (!o_valid || cur !== saved)) stall_breaks++;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && (o_valid || o_busy)) late_act++;
            start = poke && (cyc == 5 || cyc == 12 || o_done);
            ready = ($urandom_range(0, 99) >= stall_pct);
            if (o_valid && ready) begin
                obs_q.push_back(cur);
                last_acc = cyc;
            end
            prev_stall = o_valid && !ready;
            saved = cur;
            if ((done_cyc >= 0 && cyc >= done_cyc + 4) || cyc >= 5000) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; ready = 1'b1;
        if (done_cyc < 0) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        sel = 0; rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({o_busy, o_done, o_valid} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl busy/done/valid=%b expected 000", {o_busy, o_done, o_valid});
        end
        checks++; if (cur.row !== 8'd0 || cur.col !== 8'd0 || cur.ki !== 8'd0 || cur.kj !== 8'd0 ||
                      cur.m_base !== 8'd0 || cur.n_base !== 8'd0 || cur.in_row !== 8'd0) begin
            failures++; $display("FAIL reset_idx got %h expected zero indices", cur);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({o_busy, o_valid} !== 2'b00) begin
            failures++; $display("FAIL idle_after_reset busy/valid=%b expected 00", {o_busy, o_valid});
        end
    endtask

    task automatic test_default_sweep();
        int nf, nl;
        sel = 0; build_model(); run_job(0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL default_timeout no done_o seen"); end
        checks++; if (obs_q.size() !== 16) begin
            failures++; $display("FAIL default_count got %0d expected 16", obs_q.size());
        end
        nf = 0; nl = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            nf += int'(obs_q[i].first); nl += int'(obs_q[i].last);
            checks++; if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL default_step[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++; if (nf !== 16 || nl !== 16) begin
            failures++; $display("FAIL default_tags first=%0d last=%0d expected 16/16", nf, nl);
        end
        checks++; if (done_cyc !== 16 + PIPE + 1) begin
            failures++; $display("FAIL default_done_cycle got %0d expected %0d", done_cyc, 16 + PIPE + 1);
        end
        checks++; if (done_cnt !== 1 || late_act !== 0) begin
            failures++; $display("FAIL default_done_once done_cnt=%0d late=%0d expected 1/0", done_cnt, late_act);
        end
    endtask

    task automatic test_tiled_sweep();
        int nf, nl, bad_ncnt;
        sel = 1; build_model(); run_job(0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL tiled_timeout no done_o seen"); end
        checks++; if (obs_q.size() !== 576) begin
            failures++; $display("FAIL tiled_count got %0d expected 576", obs_q.size());
        end
        nf = 0; nl = 0; bad_ncnt = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            nf += int'(obs_q[i].first); nl += int'(obs_q[i].last);
            if ((obs_q[i].n_base == 8'd0 && obs_q[i].n_cnt != 8'd2) ||
                (obs_q[i].n_base == 8'd2 && obs_q[i].n_cnt != 8'd1)) bad_ncnt++;
            checks++; if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL tiled_step[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++; if (nf !== 32 || nl !== 32) begin
            failures++; $display("FAIL tiled_tags first=%0d last=%0d expected 32/32", nf, nl);
        end
        checks++; if (bad_ncnt !== 0) begin
            failures++; $display("FAIL tiled_ncnt bad=%0d expected 0", bad_ncnt);
        end
        checks++; if (done_cyc !== last_acc + PIPE + 1 || done_cnt !== 1) begin
            failures++; $display("FAIL tiled_done got cyc=%0d cnt=%0d expected cyc=%0d cnt=1",
                                 done_cyc, done_cnt, last_acc + PIPE + 1);
        end
    endtask

    task automatic test_stall();
        sel = 1; build_model(); run_job(50, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL stall_timeout no done_o seen"); end
        checks++; if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL stall_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL stall_step[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++; if (stall_breaks !== 0) begin
            failures++; $display("FAIL stall_stable changes=%0d expected 0", stall_breaks);
        end
        checks++; if (done_cyc !== last_acc + PIPE + 1 || done_cnt !== 1) begin
            failures++; $display("FAIL stall_done got cyc=%0d cnt=%0d expected cyc=%0d cnt=1",
                                 done_cyc, done_cnt, last_acc + PIPE + 1);
        end
    endtask

    task automatic test_stride();
        int hits;
        sel = 2; build_model(); run_job(30, 1'b0);
        checks++; if (obs_q.size() !== 36) begin
            failures++; $display("FAIL stride_count got %0d expected 36", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL stride_step[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        hits = 0;
        foreach (obs_q[i])
            if (obs_q[i].row == 8'd1 && obs_q[i].col == 8'd1 && obs_q[i].ki == 8'd2 && obs_q[i].kj == 8'd2) begin
                hits++;
                checks++; if (obs_q[i].in_row !== 8'd4 || obs_q[i].in_col !== 8'd4) begin
                    failures++; $display("FAIL stride_corner in_row=%0d in_col=%0d expected 4/4",
                                         obs_q[i].in_row, obs_q[i].in_col);
                end
            end
        checks++; if (hits !== 1) begin
            failures++; $display("FAIL stride_corner_seen got %0d expected 1", hits);
        end
    endtask

    task automatic test_reset_mid_run();
        int acc, guard, dseen;
        sel = 1; build_model();
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        acc = 0; guard = 0;
        while (acc < 100 && guard < 2000) begin
            if (o_valid && ready) acc++;
            @(negedge clk);
            guard++;
        end
        checks++; if (acc !== 100 || o_valid !== 1'b1) begin
            failures++; $display("FAIL midrun_reach acc=%0d valid=%b expected 100/1", acc, o_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({o_valid, o_busy} !== 2'b00) begin
            failures++; $display("FAIL midrun_async valid/busy=%b expected 00", {o_valid, o_busy});
        end
        dseen = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done) dseen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (o_done) dseen++;
        checks++; if (dseen !== 0) begin
            failures++; $display("FAIL midrun_no_done got %0d done pulses expected 0", dseen);
        end
        run_job(0, 1'b0);
        checks++; if (obs_q.size() === 0 || obs_q[0] !== exp_q[0] || obs_q[0].row !== 8'd0 ||
                      obs_q[0].col !== 8'd0 || obs_q[0].ki !== 8'd0 || obs_q[0].kj !== 8'd0) begin
            failures++; $display("FAIL restart_step0 got %h expected %h",
                                 (obs_q.size() > 0) ? obs_q[0] : step_t'('0), exp_q[0]);
        end
        checks++; if (obs_q.size() !== 576 || done_cnt !== 1) begin
            failures++; $display("FAIL restart_full count=%0d done=%0d expected 576/1", obs_q.size(), done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        sel = 0; build_model(); run_job(0, 1'b1);
        checks++; if (obs_q.size() !== 16) begin
            failures++; $display("FAIL ignore_start_count got %0d expected 16", obs_q.size());
        end
        checks++; if (done_cnt !== 1 || late_act !== 0) begin
            failures++; $display("FAIL ignore_start_done done_cnt=%0d late=%0d expected 1/0", done_cnt, late_act);
        end
        checks++; if (done_cyc !== 16 + PIPE + 1) begin
            failures++; $display("FAIL ignore_start_cycle got %0d expected %0d", done_cyc, 16 + PIPE + 1);
        end
        run_job(0, 1'b0);
        checks++; if (obs_q.size() !== 16 || obs_q[0] !== exp_q[0] || done_cnt !== 1) begin
            failures++; $display("FAIL back_to_back count=%0d done=%0d expected 16/1", obs_q.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_tiled_sweep();
        test_stall();
        test_stride();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
